// File: rtl/imm_encode_loader.sv
// imm_encode_loader: range-checks a signed constant against a 3-bit shift-amount
// or 6-bit jump field, packs it with an opcode into an 8-bit instruction word and
// writes the word to instruction memory. Writes go to consecutive addresses from
// BASE_ADDR, and the module tracks errors, overflow and the write count for each session.
module imm_encode_loader #(
    parameter int ADDR_W    = 8,
    parameter int DEPTH     = 256,
    parameter int BASE_ADDR = 0,
    parameter int SAT_MODE  = 0
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    input  logic              i_in_immsel,
    input  logic [4:0]        i_in_op,
    input  logic [7:0]        i_in_const,
    input  logic              i_in_last,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [7:0]        o_mem_wdata,
    input  logic              i_mem_ack,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_overflow,
    output logic              o_err,
    output logic [7:0]        o_err_count,
    output logic [ADDR_W:0]   o_wr_count
);

    localparam logic [ADDR_W-1:0] BASE_A  = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] ADR_ONE = ADDR_W'(1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ACCEPT = 3'd1,
        S_CHECK  = 3'd2,
        S_WRITE  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t r_state;
    state_t w_next;

    // captured input item
    logic              r_immsel;
    logic [4:0]        r_op;
    logic [7:0]        r_const;
    logic              r_last;

    // registered outputs
    logic              r_in_ready;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [7:0]        r_mem_wdata;
    logic              r_busy;
    logic              r_done;
    logic              r_overflow;
    logic              r_err;
    logic [7:0]        r_err_count;
    logic [ADDR_W:0]   r_wr_count;

    logic              w_in_range;
    logic              w_drop;
    logic              w_depth_hit;
    logic [7:0]        w_wdata;

    // Signed range test: shamt field holds -4..3, jump field holds -32..31.
    function automatic logic f_in_range(input logic immsel, input logic [7:0] c);
        logic signed [7:0] s;
        s = c;
        if (immsel) begin
            f_in_range = (s >= -8'sd32) && (s <= 8'sd31);
        end else begin
            f_in_range = (s >= -8'sd4) && (s <= 8'sd3);
        end
    endfunction

    // Saturate the constant to the nearest limit of its field.
    function automatic logic [7:0] f_clamp(input logic immsel, input logic [7:0] c);
        logic signed [7:0] s;
        logic signed [7:0] lo;
        logic signed [7:0] hi;
        s = c;
        if (immsel) begin
            lo = -8'sd32;
            hi = 8'sd31;
        end else begin
            lo = -8'sd4;
            hi = 8'sd3;
        end
        if (s < lo) begin
            f_clamp = lo;
        end else if (s > hi) begin
            f_clamp = hi;
        end else begin
            f_clamp = c;
        end
    endfunction

    // Pack opcode and low constant bits into the instruction word.
    function automatic logic [7:0] f_encode(input logic immsel, input logic [4:0] op,
                                            input logic [7:0] c);
        if (immsel) begin
            f_encode = {op[1:0], c[5:0]};
        end else begin
            f_encode = {op[4:0], c[2:0]};
        end
    endfunction

    assign w_in_range  = f_in_range(r_immsel, r_const);
    assign w_drop      = ~w_in_range & (SAT_MODE == 0);
    assign w_wdata     = f_encode(r_immsel, r_op, f_clamp(r_immsel, r_const));
    assign w_depth_hit = ((r_wr_count + CNT_ONE) == DEPTH_C);

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode for the load session.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_next = S_ACCEPT;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_ACCEPT: begin
                if (i_in_valid) begin
                    w_next = S_CHECK;
                end else begin
                    w_next = S_ACCEPT;
                end
            end
            S_CHECK: begin
                if (w_drop) begin
                    w_next = r_last ? S_DONE : S_ACCEPT;
                end else begin
                    w_next = S_WRITE;
                end
            end
            S_WRITE: begin
                if (!i_mem_ack) begin
                    w_next = S_WRITE;
                end else if (r_last || w_depth_hit) begin
                    w_next = S_DONE;
                end else begin
                    w_next = S_ACCEPT;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Item capture, encoding, counters, flags and registered handshake outputs.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_immsel    <= 1'b0;
            r_op        <= 5'd0;
            r_const     <= 8'd0;
            r_last      <= 1'b0;
            r_in_ready  <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= BASE_A;
            r_mem_wdata <= 8'd0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_overflow  <= 1'b0;
            r_err       <= 1'b0;
            r_err_count <= 8'd0;
            r_wr_count  <= '0;
        end else begin
            r_in_ready <= (w_next == S_ACCEPT);
            r_mem_we   <= (w_next == S_WRITE);
            r_busy     <= (w_next != S_IDLE);
            r_done     <= (w_next == S_DONE);
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_overflow  <= 1'b0;
                        r_err       <= 1'b0;
                        r_err_count <= 8'd0;
                        r_wr_count  <= '0;
                        r_mem_addr  <= BASE_A;
                    end
                end
                S_ACCEPT: begin
                    if (i_in_valid) begin
                        r_immsel <= i_in_immsel;
                        r_op     <= i_in_op;
                        r_const  <= i_in_const;
                        r_last   <= i_in_last;
                    end
                end
                S_CHECK: begin
                    r_mem_wdata <= w_wdata;
                    if (!w_in_range) begin
                        r_err <= 1'b1;
                        if (r_err_count != 8'hFF) begin
                            r_err_count <= r_err_count + 8'd1;
                        end
                    end
                end
                S_WRITE: begin
                    if (i_mem_ack) begin
                        r_wr_count <= r_wr_count + CNT_ONE;
                        r_mem_addr <= r_mem_addr + ADR_ONE;
                        if (!r_last && w_depth_hit) begin
                            r_overflow <= 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_in_ready  = r_in_ready;
    assign o_mem_we    = r_mem_we;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_overflow  = r_overflow;
    assign o_err       = r_err;
    assign o_err_count = r_err_count;
    assign o_wr_count  = r_wr_count;

endmodule

// File: tb/tb_imm_encode_loader.sv
// Testbench for imm_encode_loader: three instances (drop mode, clamp mode with a
// wrapping base address, and a 4-word depth) share one stimulus bus; each session
// drives exactly one of them through its own start line.
module tb_imm_encode_loader;

    logic       clk = 1'b0;
    logic       i_reset;
    logic [2:0] start_v;
    logic       i_in_valid;
    logic       i_in_immsel;
    logic [4:0] i_in_op;
    logic [7:0] i_in_const;
    logic       i_in_last;
    logic       mem_ack;
    logic       ack_level;
    logic       rand_ack;
    logic       ack_rnd;

    logic [2:0] w_rdy, w_we, w_busy, w_done, w_ovf, w_err;
    logic [7:0] w_addr  [3];
    logic [7:0] w_wdata [3];
    logic [7:0] w_errc  [3];
    logic [8:0] w_wrc   [3];

    int n_cmp  = 0;
    int n_fail = 0;
    int done_cnt [3];
    int hs_cnt   [3];
    logic [17:0] wq[$];   // observed writes {sel, addr, data}
    logic [17:0] eq[$];   // expected writes

    always #5 clk = ~clk;

    assign mem_ack = rand_ack ? ack_rnd : ack_level;

    // Random acknowledge pattern, updated away from the active edge.
    always @(negedge clk) ack_rnd <= 1'($urandom_range(0, 1));

    imm_encode_loader #(.ADDR_W(8), .DEPTH(256), .BASE_ADDR(0), .SAT_MODE(0)) u_dut0 (
        .i_clk(clk), .i_reset(i_reset), .i_start(start_v[0]), .i_in_valid(i_in_valid),
        .o_in_ready(w_rdy[0]), .i_in_immsel(i_in_immsel), .i_in_op(i_in_op),
        .i_in_const(i_in_const), .i_in_last(i_in_last), .o_mem_we(w_we[0]),
        .o_mem_addr(w_addr[0]), .o_mem_wdata(w_wdata[0]), .i_mem_ack(mem_ack),
        .o_busy(w_busy[0]), .o_done(w_done[0]), .o_overflow(w_ovf[0]), .o_err(w_err[0]),
        .o_err_count(w_errc[0]), .o_wr_count(w_wrc[0]));

    imm_encode_loader #(.ADDR_W(8), .DEPTH(256), .BASE_ADDR(250), .SAT_MODE(1)) u_dut1 (
        .i_clk(clk), .i_reset(i_reset), .i_start(start_v[1]), .i_in_valid(i_in_valid),
        .o_in_ready(w_rdy[1]), .i_in_immsel(i_in_immsel), .i_in_op(i_in_op),
        .i_in_const(i_in_const), .i_in_last(i_in_last), .o_mem_we(w_we[1]),
        .o_mem_addr(w_addr[1]), .o_mem_wdata(w_wdata[1]), .i_mem_ack(mem_ack),
        .o_busy(w_busy[1]), .o_done(w_done[1]), .o_overflow(w_ovf[1]), .o_err(w_err[1]),
        .o_err_count(w_errc[1]), .o_wr_count(w_wrc[1]));

    imm_encode_loader #(.ADDR_W(8), .DEPTH(4), .BASE_ADDR(0), .SAT_MODE(0)) u_dut2 (
        .i_clk(clk), .i_reset(i_reset), .i_start(start_v[2]), .i_in_valid(i_in_valid),
        .o_in_ready(w_rdy[2]), .i_in_immsel(i_in_immsel), .i_in_op(i_in_op),
        .i_in_const(i_in_const), .i_in_last(i_in_last), .o_mem_we(w_we[2]),
        .o_mem_addr(w_addr[2]), .o_mem_wdata(w_wdata[2]), .i_mem_ack(mem_ack),
        .o_busy(w_busy[2]), .o_done(w_done[2]), .o_overflow(w_ovf[2]), .o_err(w_err[2]),
        .o_err_count(w_errc[2]), .o_wr_count(w_wrc[2]));

    // Record completed writes, done pulses and input handshakes (pre-edge values).
    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (w_we[k] && mem_ack) wq.push_back({2'(k), w_addr[k], w_wdata[k]});
            if (w_done[k]) done_cnt[k]++;
            if (w_rdy[k] && i_in_valid) hs_cnt[k]++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: field limits, saturation and packing computed with integer arithmetic.
    function automatic void model(input logic imm, input logic [4:0] op, input logic [7:0] c,
                                  input bit sat, output logic [7:0] word, output bit oor,
                                  output bit wr);
        int v;
        int lo;
        int hi;
        int cv;
        int fw;
        int m;
        v  = int'($signed(c));
        lo = imm ? -32 : -4;
        hi = imm ? 31 : 3;
        fw = imm ? 64 : 8;
        oor = (v < lo) || (v > hi);
        cv = (v < lo) ? lo : ((v > hi) ? hi : v);
        wr = !oor || sat;
        m  = ((cv % fw) + fw) % fw;
        word = imm ? 8'(int'(op[1:0]) * 64 + m) : 8'(int'(op) * 8 + m);
    endfunction

    task automatic start_session(input int sel);
        @(negedge clk);
        wq.delete();
        start_v[sel] = 1'b1;
        @(negedge clk);
        start_v = 3'b000;
    endtask

    task automatic push_item(input int sel, input logic imm, input logic [4:0] op,
                             input logic [7:0] c, input logic last);
        int n;
        n = 0;
        i_in_valid = 1'b1; i_in_immsel = imm; i_in_op = op; i_in_const = c; i_in_last = last;
        while (w_rdy[sel] !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            n_cmp++; n_fail++;
            $display("FAIL push_timeout dut%0d: in_ready never seen", sel);
        end
        @(negedge clk);
        i_in_valid = 1'b0;
    endtask

    task automatic wait_done(input int sel);
        int n;
        n = 0;
        while (w_busy[sel] !== 1'b0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) begin
            n_cmp++; n_fail++;
            $display("FAIL done_timeout dut%0d: busy still %b", sel, w_busy[sel]);
        end
    endtask

    task automatic wait_we(input int sel);
        int n;
        n = 0;
        while (w_we[sel] !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            n_cmp++; n_fail++;
            $display("FAIL we_timeout dut%0d: mem_we never asserted", sel);
        end
    endtask

    task automatic test_reset;
        i_reset = 1'b1;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if ({w_rdy[k], w_we[k], w_busy[k], w_done[k], w_ovf[k], w_err[k]} !== 6'b0) begin
                n_fail++;
                $display("FAIL reset_flags dut%0d: got %b want 000000", k,
                         {w_rdy[k], w_we[k], w_busy[k], w_done[k], w_ovf[k], w_err[k]});
            end
            n_cmp++;
            if (w_errc[k] !== 8'd0 || w_wrc[k] !== 9'd0 || w_wdata[k] !== 8'd0) begin
                n_fail++;
                $display("FAIL reset_counts dut%0d: errc=%0d wrc=%0d wdata=%h want 0", k,
                         w_errc[k], w_wrc[k], w_wdata[k]);
            end
        end
        n_cmp++;
        if (w_addr[0] !== 8'd0 || w_addr[1] !== 8'd250 || w_addr[2] !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_addr: got %0d/%0d/%0d want 0/250/0", w_addr[0], w_addr[1], w_addr[2]);
        end
        i_reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_jump_basic;
        int dc;
        dc = done_cnt[0];
        start_session(0);
        push_item(0, 1'b1, 5'b00010, 8'hFD, 1'b1);
        wait_done(0);
        n_cmp++;
        if (wq.size() != 1 || wq[0] !== {2'd0, 8'h00, 8'hBD}) begin
            n_fail++;
            $display("FAIL jump_basic_write: got %0d writes first=%h want 1 write %h", wq.size(),
                     (wq.size() > 0) ? wq[0] : 18'h0, {2'd0, 8'h00, 8'hBD});
        end
        n_cmp++;
        if (done_cnt[0] != dc + 1 || w_err[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL jump_basic_done: done pulses=%0d err=%b want 1 and 0", done_cnt[0] - dc, w_err[0]);
        end
    endtask

    task automatic test_shamt;
        logic [7:0] wv;
        logic signed [2:0] f3;
        start_session(0);
        push_item(0, 1'b0, 5'h1A, 8'd3, 1'b0);
        push_item(0, 1'b0, 5'h1A, 8'hFC, 1'b1);
        wait_done(0);
        n_cmp++;
        if (wq.size() != 2) begin
            n_fail++;
            $display("FAIL shamt_count: got %0d writes want 2", wq.size());
        end else begin
            n_cmp++;
            if (wq[0] !== {2'd0, 8'd0, 8'hD3}) begin
                n_fail++;
                $display("FAIL shamt_word0: got %h want %h", wq[0], {2'd0, 8'd0, 8'hD3});
            end
            wv = wq[0][7:0]; f3 = wv[2:0];
            n_cmp++;
            if (int'(f3) != 3) begin
                n_fail++;
                $display("FAIL shamt_decode0: got %0d want 3", int'(f3));
            end
            wv = wq[1][7:0]; f3 = wv[2:0];
            n_cmp++;
            if (wq[1][17:8] !== {2'd0, 8'd1} || wv[2:0] !== 3'b100 || int'(f3) != -4) begin
                n_fail++;
                $display("FAIL shamt_word1: got %h decode %0d want addr 1 low 100 decode -4", wq[1], int'(f3));
            end
        end
    endtask

    task automatic test_drop;
        start_session(0);
        push_item(0, 1'b0, 5'h05, 8'd5, 1'b0);
        push_item(0, 1'b0, 5'h02, 8'h01, 1'b1);
        wait_done(0);
        n_cmp++;
        if (wq.size() != 1 || wq[0] !== {2'd0, 8'd0, 8'h11}) begin
            n_fail++;
            $display("FAIL drop_write: got %0d writes first=%h want 1 write %h", wq.size(),
                     (wq.size() > 0) ? wq[0] : 18'h0, {2'd0, 8'd0, 8'h11});
        end
        n_cmp++;
        if (w_err[0] !== 1'b1 || w_errc[0] !== 8'd1 || w_wrc[0] !== 9'd1) begin
            n_fail++;
            $display("FAIL drop_flags: err=%b errc=%0d wrc=%0d want 1/1/1", w_err[0], w_errc[0], w_wrc[0]);
        end
    endtask

    task automatic test_sat;
        logic [7:0] wv;
        start_session(1);
        push_item(1, 1'b1, 5'b00001, 8'd100, 1'b0);
        push_item(1, 1'b1, 5'b00011, 8'h9C, 1'b1);
        wait_done(1);
        n_cmp++;
        if (wq.size() != 2) begin
            n_fail++;
            $display("FAIL sat_count: got %0d writes want 2", wq.size());
        end else begin
            wv = wq[0][7:0];
            n_cmp++;
            if (wv[5:0] !== 6'h1F || wq[0] !== {2'd1, 8'd250, 8'h5F}) begin
                n_fail++;
                $display("FAIL sat_hi: got %h want %h", wq[0], {2'd1, 8'd250, 8'h5F});
            end
            wv = wq[1][7:0];
            n_cmp++;
            if (wv[5:0] !== 6'h20 || wq[1] !== {2'd1, 8'd251, 8'hE0}) begin
                n_fail++;
                $display("FAIL sat_lo: got %h want %h", wq[1], {2'd1, 8'd251, 8'hE0});
            end
        end
        n_cmp++;
        if (w_errc[1] !== 8'd2 || w_err[1] !== 1'b1 || w_wrc[1] !== 9'd2) begin
            n_fail++;
            $display("FAIL sat_flags: errc=%0d err=%b wrc=%0d want 2/1/2", w_errc[1], w_err[1], w_wrc[1]);
        end
    endtask

    task automatic test_stall;
        logic [7:0] a0;
        logic [7:0] d0;
        ack_level = 1'b0;
        start_session(0);
        push_item(0, 1'b0, 5'h07, 8'h02, 1'b1);
        wait_we(0);
        a0 = w_addr[0]; d0 = w_wdata[0];
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (w_we[0] !== 1'b1 || w_addr[0] !== a0 || w_wdata[0] !== d0 || w_rdy[0] !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_hold cyc%0d: we=%b addr=%h wdata=%h rdy=%b want 1/%h/%h/0",
                         i, w_we[0], w_addr[0], w_wdata[0], w_rdy[0], a0, d0);
            end
            @(negedge clk);
        end
        ack_level = 1'b1;
        wait_done(0);
        n_cmp++;
        if (wq.size() != 1 || wq[0] !== {2'd0, 8'd0, 8'h3A}) begin
            n_fail++;
            $display("FAIL stall_write: got %0d writes first=%h want 1 write %h", wq.size(),
                     (wq.size() > 0) ? wq[0] : 18'h0, {2'd0, 8'd0, 8'h3A});
        end
    endtask

    task automatic test_overflow;
        int dc;
        int hc;
        dc = done_cnt[2];
        hc = hs_cnt[2];
        start_session(2);
        for (int i = 0; i < 4; i++) push_item(2, 1'b0, 5'(i), 8'(i), 1'b0);
        i_in_valid = 1'b1; i_in_immsel = 1'b0; i_in_op = 5'd9; i_in_const = 8'd1; i_in_last = 1'b0;
        wait_done(2);
        repeat (6) @(negedge clk);
        i_in_valid = 1'b0;
        n_cmp++;
        if (wq.size() != 4) begin
            n_fail++;
            $display("FAIL ovf_count: got %0d writes want 4", wq.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_cmp++;
                if (wq[i] !== {2'd2, 8'(i), 8'(i * 8 + i)}) begin
                    n_fail++;
                    $display("FAIL ovf_write%0d: got %h want %h", i, wq[i], {2'd2, 8'(i), 8'(i * 8 + i)});
                end
            end
        end
        n_cmp++;
        if (w_ovf[2] !== 1'b1 || w_wrc[2] !== 9'd4 || done_cnt[2] != dc + 1 || hs_cnt[2] != hc + 4) begin
            n_fail++;
            $display("FAIL ovf_flags: ovf=%b wrc=%0d done=%0d accepted=%0d want 1/4/1/4",
                     w_ovf[2], w_wrc[2], done_cnt[2] - dc, hs_cnt[2] - hc);
        end
    endtask

    task automatic rand_session(input int sel, input bit sat, input int base);
        int n;
        int ec;
        int wc;
        int dc;
        logic imm;
        logic [4:0] op;
        logic [7:0] c;
        logic [7:0] word;
        bit oor;
        bit wr;
        n = $urandom_range(1, 12);
        ec = 0; wc = 0;
        dc = done_cnt[sel];
        eq.delete();
        start_session(sel);
        for (int i = 0; i < n; i++) begin
            imm = 1'($urandom_range(0, 1));
            op  = 5'($urandom);
            c   = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 80) - 40);
            model(imm, op, c, sat, word, oor, wr);
            if (oor) ec++;
            if (wr) begin
                eq.push_back({2'(sel), 8'((base + wc) % 256), word});
                wc++;
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
            push_item(sel, imm, op, c, 1'(i == n - 1));
        end
        wait_done(sel);
        n_cmp++;
        if (wq.size() != eq.size()) begin
            n_fail++;
            $display("FAIL rand_count dut%0d: got %0d writes want %0d", sel, wq.size(), eq.size());
        end else begin
            for (int i = 0; i < eq.size(); i++) begin
                n_cmp++;
                if (wq[i] !== eq[i]) begin
                    n_fail++;
                    $display("FAIL rand_write dut%0d #%0d: got %h want %h", sel, i, wq[i], eq[i]);
                end
            end
        end
        n_cmp++;
        if (w_errc[sel] !== 8'(ec) || w_err[sel] !== 1'(ec > 0) || w_wrc[sel] !== 9'(wc) ||
            w_ovf[sel] !== 1'b0 || done_cnt[sel] != dc + 1) begin
            n_fail++;
            $display("FAIL rand_status dut%0d: errc=%0d err=%b wrc=%0d ovf=%b done=%0d want %0d/%0d/%0d/0/1",
                     sel, w_errc[sel], w_err[sel], w_wrc[sel], w_ovf[sel], done_cnt[sel] - dc,
                     ec, (ec > 0), wc);
        end
    endtask

    task automatic test_random;
        rand_ack = 1'b1;
        for (int s = 0; s < 6; s++) begin
            rand_session(0, 1'b0, 0);
            rand_session(1, 1'b1, 250);
        end
        rand_ack = 1'b0;
    endtask

    task automatic test_reset_mid_write;
        ack_level = 1'b0;
        start_session(0);
        push_item(0, 1'b1, 5'd1, 8'd5, 1'b1);
        wait_we(0);
        i_reset = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (w_we[0] !== 1'b0 || w_busy[0] !== 1'b0 || w_addr[0] !== 8'd0 || wq.size() != 0) begin
            n_fail++;
            $display("FAIL reset_mid_write: we=%b busy=%b addr=%0d writes=%0d want 0/0/0/0",
                     w_we[0], w_busy[0], w_addr[0], wq.size());
        end
        i_reset = 1'b0;
        ack_level = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        i_reset = 1'b1; start_v = 3'b000; i_in_valid = 1'b0; i_in_immsel = 1'b0;
        i_in_op = 5'd0; i_in_const = 8'd0; i_in_last = 1'b0;
        ack_level = 1'b1; rand_ack = 1'b0;
        for (int k = 0; k < 3; k++) begin
            done_cnt[k] = 0;
            hs_cnt[k] = 0;
        end
        test_reset();
        test_jump_basic();
        test_shamt();
        test_drop();
        test_sat();
        test_stall();
        test_overflow();
        test_random();
        test_reset_mid_write();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
